serial_subtractor: RTL and testbench
====================================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter BITS, default 8, SHALL set the operand and result width in bits; legal values are 2 to 32.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on the rising edge.
REQ-003 rst  input  1  SHALL be a synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 start  input  1  SHALL request one operation; it is sampled only in IDLE.
REQ-005 A  input  BITS  SHALL carry the minuend, signed two's complement; it is captured when start is accepted.
REQ-006 B  input  BITS  SHALL carry the subtrahend, signed two's complement; it is captured when start is accepted.
REQ-007 busy  output  1  SHALL be high while in SHIFT or DONE.
REQ-008 done  output  1  SHALL be a one-cycle pulse that marks S, Z, N, P and V as newly valid.
REQ-009 S  output  BITS  SHALL carry the result A - B, wrapped modulo 2^BITS and signed.
REQ-010 Z  output  1  SHALL be high when S equals 0.
REQ-011 N  output  1  SHALL equal S[BITS-1].
REQ-012 P  output  1  SHALL be high when S is even (~S[0]).
REQ-013 V  output  1  SHALL be high on signed overflow of A - B.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-015 In IDLE with start=1 the block SHALL latch A and B into shift registers, set the carry to 1, clear the bit counter and go to SHIFT.
REQ-016 In IDLE with start=0 the block SHALL stay in IDLE.
REQ-017 Each SHIFT cycle SHALL compute one result bit, LSB first: r = a0 XOR ~b0 XOR c, with next c = majority(a0, ~b0, c).
REQ-018 Each SHIFT cycle SHALL shift both operand registers right by one, shift r into the result register at the MSB, and increment the counter.
REQ-019 SHIFT SHALL last exactly BITS cycles; after the BITS-th bit the FSM SHALL go to DONE.
REQ-020 DONE SHALL last one cycle: done=1, and S, Z, N, P and V SHALL update in that same cycle; the FSM then goes to IDLE.
REQ-021 done SHALL rise exactly BITS+1 cycles after the edge that accepted start (9 cycles for BITS=8).
REQ-022 The final carry SHALL be discarded, so S wraps modulo 2^BITS.
REQ-023 V SHALL equal (A[BITS-1] != B[BITS-1]) AND (S[BITS-1] != A[BITS-1]), using the captured operands.
REQ-024 S and all flags SHALL hold their values until the next DONE cycle or reset; they SHALL NOT change during SHIFT.
REQ-025 start SHALL be ignored in SHIFT and DONE, with no queuing; the minimum start-to-start spacing is BITS+2 cycles.
REQ-026 Changes on A or B after capture SHALL NOT affect the operation in progress.
REQ-027 The block SHALL need no input stability beyond the cycle in which start is accepted.

Reset
REQ-028 With rst=1, on the next rising edge the FSM SHALL go to IDLE.
REQ-029 That same edge SHALL clear busy=0, done=0, S=0, N=0, V=0 and the counter.
REQ-030 That same edge SHALL set Z=1 and P=1, consistent with S=0.
REQ-031 Reset during SHIFT or DONE SHALL abort the operation; no done pulse SHALL be produced for it.
REQ-032 rst SHALL take priority over start in the same cycle.
REQ-033 start SHALL be accepted on the first edge after rst deasserts.

Verification
REQ-034 BITS=8, A=5, B=3, start pulse -> done 9 cycles later, with S=0x02, Z=0, N=0, P=1, V=0.
REQ-035 A=3, B=5 -> S=0xFE (-2), Z=0, N=1, P=1, V=0.
REQ-036 A=0x80 (-128), B=0x01 -> S=0x7F, N=0, P=0, V=1; and A=0x7F, B=0xFF -> S=0x80, N=1, V=1.
REQ-037 A=7, B=7 -> S=0x00, Z=1, N=0, P=1, V=0.
REQ-038 start held high for 20 cycles with A=9, B=4 -> exactly one done in cycles 1-11, S=0x05; change A and B mid-SHIFT -> result unchanged.
REQ-039 rst=1 at SHIFT cycle 4 -> no done pulse, all outputs at reset values; a new start after that -> correct result 9 cycles later.

Source files
------------

// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for the bit-serial subtractor.
interface serial_subtractor_if #(
    parameter int unsigned BITS = 8
);
    logic            start;
    logic [BITS-1:0] A;
    logic [BITS-1:0] B;
    logic            busy;
    logic            done;
    logic [BITS-1:0] S;
    logic            Z;
    logic            N;
    logic            P;
    logic            V;

    modport master (output start, A, B, input busy, done, S, Z, N, P, V);
    modport slave  (input start, A, B, output busy, done, S, Z, N, P, V);
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial two's complement subtractor: S = A - B, one bit per cycle, LSB first,
// with zero/negative/even/overflow flags published on a one-cycle done pulse.
module serial_subtractor #(
    parameter int unsigned BITS = 8
) (
    input  logic                clk,
    input  logic                rst,
    serial_subtractor_if.slave  bus
);
    localparam int unsigned CW = $clog2(BITS + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t          r_state;
    state_t          w_next;
    logic [BITS-1:0] r_a;
    logic [BITS-1:0] r_b;
    logic [BITS-1:0] r_res;
    logic            r_a_sign;
    logic            r_b_sign;
    logic            r_c;
    logic [CW-1:0]   r_cnt;
    logic            r_busy;
    logic            r_done;
    logic [BITS-1:0] r_s;
    logic            r_z;
    logic            r_n;
    logic            r_p;
    logic            r_v;
    logic            w_nb;
    logic            w_bit;
    logic            w_cout;

    // A - B = A + ~B + 1: full adder on the inverted subtrahend bit
    assign w_nb   = ~r_b[0];
    assign w_bit  = r_a[0] ^ w_nb ^ r_c;
    assign w_cout = (r_a[0] & w_nb) | (r_a[0] & r_c) | (w_nb & r_c);

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.start) w_next = SHIFT;
            SHIFT:   if (r_cnt == CW'(BITS - 1)) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Datapath; published outputs only move on the edge that closes DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_res    <= '0;
            r_a_sign <= 1'b0;
            r_b_sign <= 1'b0;
            r_c      <= 1'b0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_s      <= '0;
            r_z      <= 1'b1;
            r_n      <= 1'b0;
            r_p      <= 1'b1;
            r_v      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_busy <= (w_next != IDLE);
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_a      <= bus.A;
                        r_b      <= bus.B;
                        r_a_sign <= bus.A[BITS-1];
                        r_b_sign <= bus.B[BITS-1];
                        r_c      <= 1'b1;
                        r_cnt    <= '0;
                    end
                end
                SHIFT: begin
                    r_a   <= r_a >> 1;
                    r_b   <= r_b >> 1;
                    r_res <= {w_bit, r_res[BITS-1:1]};
                    r_c   <= w_cout;
                    r_cnt <= r_cnt + CW'(1);
                end
                DONE: begin
                    r_done <= 1'b1;
                    r_s    <= r_res;
                    r_z    <= (r_res == '0);
                    r_n    <= r_res[BITS-1];
                    r_p    <= ~r_res[0];
                    r_v    <= (r_a_sign != r_b_sign) && (r_res[BITS-1] != r_a_sign);
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.S    = r_s;
    assign bus.Z    = r_z;
    assign bus.N    = r_n;
    assign bus.P    = r_p;
    assign bus.V    = r_v;
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (BITS=8): vector table plus hold-start and reset-abort sequences.
module tb_serial_subtractor;
    localparam int unsigned BITS = 8;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] s;
        logic       z;
        logic       n;
        logic       p;
        logic       v;
    } vec_t;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    serial_subtractor_if #(.BITS(BITS)) bus ();

    serial_subtractor #(.BITS(BITS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
        chk({tag, "_done"}, 32'(bus.done), 32'd0);
        chk({tag, "_S"},    32'(bus.S),    32'd0);
        chk({tag, "_Z"},    32'(bus.Z),    32'd1);
        chk({tag, "_N"},    32'(bus.N),    32'd0);
        chk({tag, "_P"},    32'(bus.P),    32'd1);
        chk({tag, "_V"},    32'(bus.V),    32'd0);
    endtask

    // One operation; operands are scrambled after capture and S must hold mid-SHIFT
    task automatic run_op(input vec_t t, input string nm);
        int         lat;
        logic [7:0] prev_s;
        lat    = 0;
        prev_s = bus.S;
        @(negedge clk);
        bus.start = 1'b1;
        bus.A     = t.a;
        bus.B     = t.b;
        @(negedge clk);
        bus.start = 1'b0;
        chk({nm, "_busy"}, 32'(bus.busy), 32'd1);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 2) begin
                bus.A = 8'($urandom);
                bus.B = 8'($urandom);
            end
            if (k == 4) chk({nm, "_hold"}, 32'(bus.S), 32'(prev_s));
            if (bus.done) begin
                lat = k;
                break;
            end
        end
        chk({nm, "_lat"}, 32'(lat), 32'(BITS + 1));
        chk({nm, "_S"}, 32'(bus.S), 32'(t.s));
        chk({nm, "_Z"}, 32'(bus.Z), 32'(t.z));
        chk({nm, "_N"}, 32'(bus.N), 32'(t.n));
        chk({nm, "_P"}, 32'(bus.P), 32'(t.p));
        chk({nm, "_V"}, 32'(bus.V), 32'(t.v));
        @(negedge clk);
        chk({nm, "_pulse"}, 32'(bus.done), 32'd0);
        chk({nm, "_keep"}, 32'(bus.S), 32'(t.s));
    endtask

    vec_t vecs[9];
    int   ndone;
    logic [7:0] s_at_done;

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.A     = '0;
        bus.B     = '0;

        //        a      b      s      z  n  p  v
        vecs[0] = '{8'h05, 8'h03, 8'h02, 0, 0, 1, 0};
        vecs[1] = '{8'h03, 8'h05, 8'hFE, 0, 1, 1, 0};
        vecs[2] = '{8'h80, 8'h01, 8'h7F, 0, 0, 0, 1};
        vecs[3] = '{8'h7F, 8'hFF, 8'h80, 0, 1, 1, 1};
        vecs[4] = '{8'h07, 8'h07, 8'h00, 1, 0, 1, 0};
        vecs[5] = '{8'h00, 8'h80, 8'h80, 0, 1, 1, 1};
        vecs[6] = '{8'h10, 8'h20, 8'hF0, 0, 1, 1, 0};
        vecs[7] = '{8'h80, 8'h7F, 8'h01, 0, 0, 0, 1};
        vecs[8] = '{8'hFF, 8'hFF, 8'h00, 1, 0, 1, 0};

        repeat (3) @(negedge clk);
        chk_reset_vals("rst");
        rst = 1'b0;

        for (int i = 0; i < 9; i++) run_op(vecs[i], $sformatf("vec%0d", i));

        // start held high: second acceptance comes only after the first completes
        ndone     = 0;
        s_at_done = '0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.A     = 8'd9;
        bus.B     = 8'd4;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.done && c >= 1 && c <= 11) begin
                ndone++;
                s_at_done = bus.S;
            end
        end
        bus.start = 1'b0;
        chk("hold_start_ndone", 32'(ndone), 32'd1);
        chk("hold_start_S", 32'(s_at_done), 32'h05);
        repeat (12) @(negedge clk);

        // reset in the middle of SHIFT aborts without a done pulse
        bus.start = 1'b1;
        bus.A     = 8'h33;
        bus.B     = 8'h11;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_reset_vals("abort");
        ndone = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (bus.done) ndone++;
        end
        chk("abort_no_done", 32'(ndone), 32'd0);
        rst = 1'b0;
        run_op('{8'h33, 8'h11, 8'h22, 0, 0, 1, 0}, "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
